// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock controller: command op codes, FSM states
// and the reset-time half-period helper.
package cpu_clk_pkg;

    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SETDIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STEP     = 2'b10,
        STOPPING = 2'b11
    } state_e;

    // Half-period in clkin cycles for a target frequency; clamped so it is never 0.
    function automatic logic [31:0] def_half_lim(input longint unsigned clkin_hz,
                                                 input longint unsigned def_hz);
        longint unsigned v;
        v = (def_hz == 0) ? 64'd1 : (clkin_hz / 2 / def_hz);
        if (v == 0) begin
            v = 1;
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/clk_halfdiv.sv
// Programmable half-period divider: owns half_cnt, half_lim and the pending reload,
// and produces clkout plus a registered tick on every rising clkout edge.
module clk_halfdiv
    import cpu_clk_pkg::*;
#(
    parameter logic [31:0] RST_LIM = 32'd25000
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        en,        // count this cycle
    input  logic        restart,   // clear half_cnt (return to a clean idle phase)
    input  logic        load,      // SET_DIV accepted this cycle
    input  logic [31:0] load_val,
    output logic        clkout,
    output logic        tick,
    output logic        rise,      // clkout goes 0->1 at this edge
    output logic        fall       // clkout goes 1->0 at this edge
);

    logic [31:0] half_cnt;
    logic [31:0] half_lim;
    logic [31:0] pend_lim;
    logic        pend_vld;
    logic        toggle;
    logic [31:0] new_lim;

    // Toggle decode from pre-command state; a zero divider request is treated as 1.
    always_comb begin
        toggle  = en && (half_cnt == half_lim - 32'd1);
        rise    = toggle && !clkout;
        fall    = toggle && clkout;
        new_lim = (load_val == 32'd0) ? 32'd1 : load_val;
    end

    // Half-period counter.
    always_ff @(posedge clkin) begin
        if (rst || restart) begin
            half_cnt <= '0;
        end else if (toggle) begin
            half_cnt <= '0;
        end else if (en) begin
            half_cnt <= half_cnt + 32'd1;
        end
    end

    // Output clock and its rising-edge tick.
    always_ff @(posedge clkin) begin
        if (rst) begin
            clkout <= 1'b0;
            tick   <= 1'b0;
        end else begin
            if (toggle) begin
                clkout <= !clkout;
            end
            tick <= rise;
        end
    end

    // Divider limit: immediate when the divider is stopped (only IDLE issues loads then),
    // otherwise held pending and applied at the next falling toggle.
    always_ff @(posedge clkin) begin
        if (rst) begin
            half_lim <= RST_LIM;
            pend_lim <= '0;
            pend_vld <= 1'b0;
        end else if (load && !en) begin
            half_lim <= new_lim;
            pend_vld <= 1'b0;
        end else begin
            if (fall && pend_vld) begin
                half_lim <= pend_lim;
            end
            if (load) begin
                pend_lim <= new_lim;
                pend_vld <= 1'b1;
            end else if (fall) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller for the CPU clock. Optional breakpoint support is
// compiled in with the CPU_BKPT_EN macro (adds bp_hit / halted_bp ports).
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned CLKIN_HZ = 50000000,
    parameter int unsigned DEF_HZ   = 1000,
    parameter int unsigned STEP_W   = 16
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_arg,
    output logic              clkout,
    output logic              tick,
    output logic              running,
    output logic [STEP_W-1:0] steps_left,
`ifdef CPU_BKPT_EN
    input  logic              bp_hit,
    output logic              halted_bp,
`endif
    output logic [31:0]       cyc_cnt
);

    localparam logic [31:0] RST_LIM = def_half_lim(CLKIN_HZ, DEF_HZ);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [31:0]       cyc_q;
    logic              en, restart, load, rise, fall;
    logic              bp_stop, acc;
    logic [STEP_W-1:0] step_n;

    assign step_n = cmd_arg[STEP_W-1:0];

`ifdef CPU_BKPT_EN
    assign bp_stop = bp_hit && (state_q == RUN || state_q == STEP);
`else
    assign bp_stop = 1'b0;
`endif

    // Divider runs while active; in STOPPING only until clkout has fallen.
    always_comb begin
        en        = (state_q == RUN) || (state_q == STEP) || (state_q == STOPPING && clkout);
        restart   = (state_q == STOPPING) && !clkout;
        cmd_ready = (state_q != STOPPING) && !bp_stop;
        acc       = cmd_valid && cmd_ready;
        running   = (state_q != IDLE);
    end

    clk_halfdiv #(
        .RST_LIM (RST_LIM)
    ) u_div (
        .clkin    (clkin),
        .rst      (rst),
        .en       (en),
        .restart  (restart),
        .load     (load),
        .load_val (cmd_arg),
        .clkout   (clkout),
        .tick     (tick),
        .rise     (rise),
        .fall     (fall)
    );

    // Next state: clock-edge effects first, then breakpoint, then an accepted command wins.
    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        load    = 1'b0;
        unique case (state_q)
            STEP: begin
                if (rise) begin
                    steps_d = steps_q - 1'b1;
                    if (steps_q == STEP_W'(1)) begin
                        state_d = STOPPING;
                    end
                end
            end
            STOPPING: begin
                if (!clkout || fall) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (bp_stop) begin
            state_d = STOPPING;
        end else if (acc) begin
            unique case (cmd_op)
                OP_HALT: begin
                    if (state_q == RUN || state_q == STEP) begin
                        state_d = STOPPING;
                    end
                end
                OP_RUN: begin
                    state_d = RUN;
                    steps_d = '0;
                end
                OP_STEP: begin
                    if (state_q == IDLE) begin
                        // STEP 0 from IDLE is accepted but does nothing
                        if (step_n != '0) begin
                            state_d = STEP;
                            steps_d = step_n;
                        end
                    end else begin
                        steps_d = step_n;
                        state_d = (step_n == '0) ? STOPPING : STEP;
                    end
                end
                OP_SETDIV: begin
                    load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, step and cycle registers.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= IDLE;
            steps_q <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            if (rise) begin
                cyc_q <= cyc_q + 32'd1;
            end
        end
    end

    assign steps_left = steps_q;
    assign cyc_cnt    = cyc_q;

`ifdef CPU_BKPT_EN
    logic bp_q;

    // Sticky breakpoint flag; cleared by the next accepted RUN or STEP.
    always_ff @(posedge clkin) begin
        if (rst) begin
            bp_q <= 1'b0;
        end else if (bp_stop) begin
            bp_q <= 1'b1;
        end else if (acc && (cmd_op == OP_RUN || cmd_op == OP_STEP)) begin
            bp_q <= 1'b0;
        end
    end

    assign halted_bp = bp_q;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl (default parameters; CPU_BKPT_EN optional).
module tb_cpu_clk_ctrl;

    logic        clkin;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        clkout;
    logic        tick;
    logic        running;
    logic [15:0] steps_left;
    logic [31:0] cyc_cnt;
`ifdef CPU_BKPT_EN
    logic        bp_hit;
    logic        halted_bp;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    cpu_clk_ctrl dut (
        .clkin      (clkin),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .clkout     (clkout),
        .tick       (tick),
        .running    (running),
        .steps_left (steps_left),
`ifdef CPU_BKPT_EN
        .bp_hit     (bp_hit),
        .halted_bp  (halted_bp),
`endif
        .cyc_cnt    (cyc_cnt)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Reference model: behaviour in terms of elapsed cycles per half period and modes.
    typedef enum int {MIdle, MRun, MStep, MStop} mmode_e;
    mmode_e          m_mode;
    bit              m_clk, m_tick, m_bp, m_pv;
    longint unsigned m_elapsed, m_lim, m_pl;
    int unsigned     m_steps;
    bit [31:0]       m_cyc;

    function automatic void model_reset();
        m_mode = MIdle; m_clk = 0; m_tick = 0; m_bp = 0; m_pv = 0;
        m_elapsed = 0; m_lim = 50000000 / 2 / 1000; m_pl = 0; m_steps = 0; m_cyc = 0;
    endfunction

    function automatic void model_cycle(input bit vld, input bit [1:0] op,
                                        input bit [31:0] arg, input bit bp);
        bit live, rise, fall, ready, bstop;
        mmode_e nxt;
        int unsigned n;
        bstop = bp && (m_mode == MRun || m_mode == MStep);
        ready = (m_mode != MStop) && !bstop;
        live  = (m_mode == MRun) || (m_mode == MStep) || (m_mode == MStop && m_clk);
        rise  = 0; fall = 0; nxt = m_mode;
        if (m_mode == MStop && !m_clk) begin
            nxt = MIdle; m_elapsed = 0;
        end
        if (live) begin
            m_elapsed++;
            if (m_elapsed == m_lim) begin
                m_elapsed = 0; rise = !m_clk; fall = m_clk; m_clk = !m_clk;
            end
        end
        m_tick = rise;
        if (rise) m_cyc++;
        if (fall && m_pv) begin m_lim = m_pl; m_pv = 0; end
        if (m_mode == MStep && rise) begin
            m_steps--;
            if (m_steps == 0) nxt = MStop;
        end
        if (m_mode == MStop && fall) nxt = MIdle;
        if (bstop) begin
            nxt = MStop; m_bp = 1;
        end else if (vld && ready) begin
            case (op)
                2'd0: if (m_mode != MIdle) nxt = MStop;
                2'd1: begin m_bp = 0; nxt = MRun; m_steps = 0; end
                2'd2: begin
                    m_bp = 0; n = arg & 32'hFFFF;
                    if (m_mode == MIdle) begin
                        if (n != 0) begin nxt = MStep; m_steps = n; end
                    end else begin
                        m_steps = n; nxt = (n == 0) ? MStop : MStep;
                    end
                end
                default: begin
                    if (m_mode == MIdle) begin
                        m_lim = (arg == 0) ? 1 : arg; m_pv = 0;
                    end else begin
                        m_pl = (arg == 0) ? 1 : arg; m_pv = 1;
                    end
                end
            endcase
        end
        m_mode = nxt;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [63:0] a, e;
        logic hb;
`ifdef CPU_BKPT_EN
        hb = halted_bp;
`else
        hb = 1'b0;
`endif
        a = {11'd0, hb, clkout, tick, running, cmd_ready, steps_left, cyc_cnt};
        e = {11'd0, m_bp, m_clk, m_tick, (m_mode != MIdle), (m_mode != MStop),
             16'(m_steps), m_cyc};
        chk("model{hbp,clk,tick,run,rdy,steps,cyc}", a, e);
    endtask

    // One clkin cycle with the given command; inputs drop after the edge, then compare.
    task automatic cyc(input bit vld, input bit [1:0] op, input bit [31:0] arg, input bit bp);
        cmd_valid = vld; cmd_op = op; cmd_arg = arg;
`ifdef CPU_BKPT_EN
        bp_hit = bp;
`endif
        @(posedge clkin);
        model_cycle(vld, op, arg, bp);
        #1;
        cmd_valid = 1'b0;
`ifdef CPU_BKPT_EN
        bp_hit = 1'b0;
`endif
        #1;
        cmp_model();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; cmd_valid = 1'b0;
        repeat (n) @(posedge clkin);
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst clkout", clkout, 0);
        chk("rst running", running, 0);
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst cyc_cnt", cyc_cnt, 0);
        chk("rst steps/tick", {steps_left, tick}, 0);
        cmp_model();
    endtask

    typedef struct {
        bit          vld;
        bit [1:0]    op;
        bit [31:0]   arg;
        int unsigned idle;
        bit          clk;
        bit          run;
        int unsigned cycs;
        int unsigned steps;
    } vec_t;

    vec_t vec[24];
    bit          r_vld, r_bp, got;
    bit [1:0]    r_op;
    bit [31:0]   r_arg;
    int unsigned n;

    initial begin
        // {vld, op, arg, idle cycles after, clkout, running, cyc_cnt, steps_left}
        vec[0]  = '{1, 2'd3, 3, 0,  0, 0, 0,  0};   // SET_DIV 3 in IDLE
        vec[1]  = '{1, 2'd1, 0, 2,  0, 1, 0,  0};   // RUN, no rise yet
        vec[2]  = '{0, 2'd0, 0, 0,  1, 1, 1,  0};   // first rise 3 cycles after accept
        vec[3]  = '{0, 2'd0, 0, 56, 0, 1, 10, 0};   // 60 cycles -> 10 rises
        vec[4]  = '{1, 2'd0, 0, 1,  0, 0, 10, 0};   // HALT with clkout low
        vec[5]  = '{1, 2'd2, 4, 0,  0, 1, 10, 4};   // STEP 4
        vec[6]  = '{0, 2'd0, 0, 2,  1, 1, 11, 3};
        vec[7]  = '{0, 2'd0, 0, 17, 1, 1, 14, 0};   // fourth rise -> STOPPING
        vec[8]  = '{0, 2'd0, 0, 2,  0, 0, 14, 0};   // 24 cycles after STEP
        vec[9]  = '{1, 2'd1, 0, 3,  1, 1, 15, 0};
        vec[10] = '{1, 2'd3, 5, 1,  1, 1, 15, 0};   // SET_DIV 5 mid high phase
        vec[11] = '{0, 2'd0, 0, 0,  0, 1, 15, 0};   // high phase still 3 cycles
        vec[12] = '{0, 2'd0, 0, 4,  1, 1, 16, 0};   // low phase 5 cycles
        vec[13] = '{0, 2'd0, 0, 3,  1, 1, 16, 0};
        vec[14] = '{0, 2'd0, 0, 0,  0, 1, 16, 0};   // high phase 5 cycles
        vec[15] = '{1, 2'd0, 0, 0,  0, 1, 16, 0};
        vec[16] = '{0, 2'd0, 0, 0,  0, 0, 16, 0};
        vec[17] = '{1, 2'd3, 0, 0,  0, 0, 16, 0};   // SET_DIV 0 -> 1
        vec[18] = '{1, 2'd1, 0, 0,  0, 1, 16, 0};
        vec[19] = '{0, 2'd0, 0, 0,  1, 1, 17, 0};   // toggles every cycle
        vec[20] = '{0, 2'd0, 0, 0,  0, 1, 17, 0};
        vec[21] = '{0, 2'd0, 0, 0,  1, 1, 18, 0};
        vec[22] = '{1, 2'd0, 0, 0,  0, 1, 18, 0};   // HALT on a fall edge
        vec[23] = '{0, 2'd0, 0, 0,  0, 0, 18, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
`ifdef CPU_BKPT_EN
        bp_hit = 1'b0;
`endif
        model_reset();
        do_reset(2);

        // Default divider: first rise 25000 cycles after RUN, then a mid-run reset.
        cyc(1, 2'd1, 0, 0);
        n = 0; got = 0;
        for (int i = 0; i < 30000 && !got; i++) begin
            cyc(0, 2'd0, 0, 0);
            n++;
            if (tick) got = 1;
        end
        chk("default half_lim rise", n, 25000);
        do_reset(1);

        for (int i = 0; i < 24; i++) begin
            cyc(vec[i].vld, vec[i].op, vec[i].arg, 0);
            for (int k = 0; k < int'(vec[i].idle); k++) cyc(0, 2'd0, 0, 0);
            chk($sformatf("vec%0d {clk,run,cyc,steps}", i),
                {vec[i].clk, vec[i].run, vec[i].cycs, 16'(vec[i].steps)},
                {clkout, running, cyc_cnt, steps_left});
        end

        // HALT one cycle after a rise: high phase completes, then IDLE with no more ticks.
        cyc(1, 2'd3, 3, 0);
        cyc(1, 2'd1, 0, 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc(0, 2'd0, 0, 0);
            if (tick) got = 1;
        end
        chk("halt: rise seen", got, 1);
        cyc(1, 2'd0, 0, 0);
        chk("halt +1 {clk,rdy,tick}", {clkout, cmd_ready, tick}, 3'b100);
        cyc(0, 2'd0, 0, 0);
        chk("halt +2 {clk,rdy,tick}", {clkout, cmd_ready, tick}, 3'b100);
        cyc(0, 2'd0, 0, 0);
        chk("halt +3 {clk,run,rdy,tick}", {clkout, running, cmd_ready, tick}, 4'b0010);

`ifdef CPU_BKPT_EN
        // Breakpoint beats a same-cycle RUN and latches halted_bp until the next RUN.
        cyc(1, 2'd1, 0, 0);
        cyc(0, 2'd0, 0, 0);
        cmd_valid = 1'b1; cmd_op = 2'd1; bp_hit = 1'b1;
        #1;
        chk("bp cmd_ready", cmd_ready, 0);
        cyc(1, 2'd1, 0, 1);
        chk("bp halted_bp set", halted_bp, 1);
        for (int i = 0; i < 20 && running; i++) cyc(0, 2'd0, 0, 0);
        chk("bp stopped {run,clk,hbp}", {running, clkout, halted_bp}, 3'b001);
        cyc(1, 2'd1, 0, 0);
        chk("bp cleared by RUN", halted_bp, 0);
        cyc(1, 2'd0, 0, 0);
        for (int i = 0; i < 20 && running; i++) cyc(0, 2'd0, 0, 0);
`endif

        // Random commands against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1);
                cyc(1, 2'd3, 2, 0);
            end else begin
                r_vld = ($urandom_range(0, 3) == 0);
                r_op  = 2'($urandom_range(0, 3));
                case (r_op)
                    2'd2:    r_arg = $urandom_range(0, 6);
                    2'd3:    r_arg = $urandom_range(0, 4);
                    default: r_arg = $urandom;
                endcase
`ifdef CPU_BKPT_EN
                r_bp = ($urandom_range(0, 15) == 0);
`else
                r_bp = 1'b0;
`endif
                cyc(r_vld, r_op, r_arg, r_bp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
